// File: rtl/seg7_scan_driver.sv
// Multiplexed BCD seven-segment scan driver with one dark cycle per digit slot.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_bcd;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic [3:0]            digit;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic                  slot_end;

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign slot_end = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            shadow_bcd <= '0;
            shadow_dp  <= '0;
        end else begin
            if (load) begin
                shadow_bcd <= bcd_in;
                shadow_dp  <= dp_in;
            end
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // lz[i] is set when digit i and every digit above it are zero
    logic [NUM_DIGITS-1:0] lz;

    always_comb begin
        lz = '0;
        lz[NUM_DIGITS-1] = (shadow_bcd[4*NUM_DIGITS-1 -: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lz[i] = (shadow_bcd[4*i +: 4] == 4'd0) && lz[i+1];
        end
    end
`endif

    always_comb begin
        digit   = shadow_bcd[4*idx +: 4];
        seg_nxt = decode(digit);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if ((idx != '0) && lz[idx]) begin
            seg_nxt = 7'h00;
        end
`endif
        dp_nxt = shadow_dp[idx];
        an_nxt = slot_end ? '0 : (NUM_DIGITS'(1) << idx);
        if (blank) begin
            seg_nxt = 7'h00;
            dp_nxt  = 1'b0;
            an_nxt  = '0;
        end
    end

    // Pin polarity is applied before the register so the pins come straight from flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= {7{INV}};
            dp  <= INV;
            an  <= {NUM_DIGITS{INV}};
        end else begin
            seg <= seg_nxt ^ {7{INV}};
            dp  <= dp_nxt ^ INV;
            an  <= an_nxt ^ {NUM_DIGITS{INV}};
        end
    end

endmodule
